// File: rtl/hazard_if.sv
// Hazard-control bundle between the pipeline datapath (master) and hazard_ctrl (slave).
interface hazard_if #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC-1:0][ADDR_W-1:0] rs_d, rs_e;
  logic [NUM_SRC-1:0]             use_d, use_e;
  logic [ADDR_W-1:0]              rd_e, rd_m, rd_w;
  logic                           regwrite_m, regwrite_w;
  logic                           load_e, pcsrc_e;
  logic                           mem_req_m, mem_ready;
  logic [NUM_SRC-1:0][1:0]        fwd_e;
  logic                           stall_f, stall_d, stall_e, stall_m;
  logic                           flush_d, flush_e, flush_w;
  logic                           mem_timeout;
  logic [CNT_W-1:0]               stall_cnt;

  modport master (
    output rs_d, rs_e, use_d, use_e, rd_e, rd_m, rd_w, regwrite_m, regwrite_w,
           load_e, pcsrc_e, mem_req_m, mem_ready,
    input  fwd_e, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
           mem_timeout, stall_cnt
  );
  modport slave (
    input  rs_d, rs_e, use_d, use_e, rd_e, rd_m, rd_w, regwrite_m, regwrite_w,
           load_e, pcsrc_e, mem_req_m, mem_ready,
    output fwd_e, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
           mem_timeout, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: per-source forwarding, load-use bubble, branch flush,
// memory-wait freeze with sticky timeout, and a saturating stall counter.
module hazard_fwd_lane #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs_e,
  input  logic [ADDR_W-1:0] rs_d,
  input  logic [ADDR_W-1:0] rd_e,
  input  logic [ADDR_W-1:0] rd_m,
  input  logic [ADDR_W-1:0] rd_w,
  input  logic              use_e,
  input  logic              use_d,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  output logic [1:0]        fwd,
  output logic              lu_hit
);
  logic valid_e;
  assign valid_e = use_e && (rs_e != '0);

  // M is the younger producer, so it wins over W
  always_comb begin
    fwd = 2'b00;
    if (valid_e && regwrite_m && (rd_m == rs_e))      fwd = 2'b10;
    else if (valid_e && regwrite_w && (rd_w == rs_e)) fwd = 2'b01;
  end

  assign lu_hit = use_d && (rd_e != '0) && (rs_d == rd_e);
endmodule

module hazard_ctrl #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input logic     clk,
  input logic     rst_n,
  hazard_if.slave bus
);
  localparam int              WC_W = $clog2(TIMEOUT + 2);
  localparam logic [WC_W-1:0] TMO  = WC_W'(TIMEOUT);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
  state_t state, state_nx;

  logic [NUM_SRC-1:0][1:0] fwd, fwd_o;
  logic [NUM_SRC-1:0]      lu_hit;
  logic                    lu, freeze;
  logic                    sf, sd, se, sm, fd, fe, fw;
  logic [WC_W-1:0]         wcnt;
  logic                    timeout_q;
  logic [CNT_W-1:0]        scnt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    hazard_fwd_lane #(.ADDR_W(ADDR_W)) u_lane (
      .rs_e(bus.rs_e[i]), .rs_d(bus.rs_d[i]), .rd_e(bus.rd_e), .rd_m(bus.rd_m),
      .rd_w(bus.rd_w), .use_e(bus.use_e[i]), .use_d(bus.use_d[i]),
      .regwrite_m(bus.regwrite_m), .regwrite_w(bus.regwrite_w),
      .fwd(fwd[i]), .lu_hit(lu_hit[i])
    );
  end

  assign lu = bus.load_e && (|lu_hit);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  // freeze drops in the ready cycle itself, so the access costs no extra cycle
  always_comb begin
    state_nx = state;
    freeze   = 1'b0;
    case (state)
      RUN:      if (bus.mem_req_m && !bus.mem_ready) begin
                  state_nx = MEM_WAIT;
                  freeze   = 1'b1;
                end
      MEM_WAIT: if (bus.mem_ready) state_nx = RUN;
                else               freeze   = 1'b1;
      default:  state_nx = RUN;
    endcase
  end

  always_comb begin
    {sf, sd, se, sm, fd, fe, fw} = '0;
    fwd_o = fwd;
    if (!rst_n) begin
      {fd, fe, fw} = 3'b111;
      fwd_o        = '0;
    end else if (freeze) begin
      {sf, sd, se, sm, fw} = 5'b11111;
    end else if (bus.pcsrc_e) begin
      {fd, fe} = 2'b11;
    end else if (lu) begin
      // bubble in E clears load_e next cycle, so this lasts one cycle by itself
      {sf, sd, fe} = 3'b111;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt      <= '0;
      timeout_q <= 1'b0;
      scnt      <= '0;
    end else begin
      if (state == RUN) wcnt <= '0;
      else begin
        if (wcnt != TMO)          wcnt      <= wcnt + 1'b1;
        if (wcnt + 1'b1 >= TMO)   timeout_q <= 1'b1;
      end
      if (sf && (scnt != '1)) scnt <= scnt + 1'b1;
    end
  end

  assign bus.fwd_e       = fwd_o;
  assign bus.stall_f     = sf;
  assign bus.stall_d     = sd;
  assign bus.stall_e     = se;
  assign bus.stall_m     = sm;
  assign bus.flush_d     = fd;
  assign bus.flush_e     = fe;
  assign bus.flush_w     = fw;
  assign bus.mem_timeout = timeout_q;
  assign bus.stall_cnt   = scnt;
endmodule
